// File: rtl/counter_pkg.sv
// Shared types for the counter/timer: end-of-count modes and run/halt states.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/counter_timer_if.sv
// Control and status bundle between a host and the counter/timer.
interface counter_timer_if #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 8
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up;
    logic [1:0]       mode;
    logic [PSC_W-1:0] psc;
    logic [WIDTH-1:0] cmp;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             match;
    logic             running;

    modport master (
        output enable, load, load_val, up, mode, psc, cmp,
        input  out, tc, match, running
    );

    modport slave (
        input  enable, load, load_val, up, mode, psc, cmp,
        output out, tc, match, running
    );
endinterface

// File: rtl/counter_prescaler.sv
// Prescaler: emits a tick once every psc+1 enabled cycles; clr parks the count at zero.
module counter_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clr,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);
    logic [PSC_W-1:0] cnt_q;

    // >= rather than == so that lowering psc below the current count still ticks.
    assign tick = enable && (cnt_q >= psc);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/counter_timer.sv
// Up/down counter/timer with prescaler, load, wrap/saturate/one-shot end-of-count modes.
module counter_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PSC_W = 8
) (
    input logic            clk,
    input logic            reset,
    counter_timer_if.slave bus
);
    state_e           state_q;
    logic [WIDTH-1:0] out_q;
    logic             tc_q;
    logic             match_q;

    logic             tick;
    logic             clr;
    logic [WIDTH-1:0] term;
    logic             at_term;
    logic [WIDTH-1:0] step_d;

    // HALT keeps the prescaler cleared so a resumed count starts a fresh interval.
    assign clr = bus.load || (state_q == ST_HALT);

    counter_prescaler #(.PSC_W(PSC_W)) u_psc (
        .clk    (clk),
        .reset  (reset),
        .enable (bus.enable),
        .clr    (clr),
        .psc    (bus.psc),
        .tick   (tick)
    );

    always_comb begin
        term    = {WIDTH{bus.up}};
        at_term = (out_q == term);
        step_d  = out_q;
        if (!at_term) begin
            step_d = bus.up ? out_q + 1'b1 : out_q - 1'b1;
        end else begin
            case (mode_e'(bus.mode))
                MODE_SAT, MODE_ONESHOT: step_d = out_q;
                default:                step_d = {WIDTH{~bus.up}};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            out_q   <= '0;
            tc_q    <= 1'b0;
            match_q <= 1'b0;
        end else if (bus.load) begin
            state_q <= ST_RUN;
            out_q   <= bus.load_val;
            tc_q    <= 1'b0;
            match_q <= 1'b0;
        end else begin
            tc_q    <= 1'b0;
            match_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (tick) begin
                        out_q   <= step_d;
                        tc_q    <= at_term;
                        match_q <= (step_d == bus.cmp);
                        if (at_term && (mode_e'(bus.mode) == MODE_ONESHOT)) begin
                            state_q <= ST_HALT;
                        end
                    end
                end
                default: state_q <= ST_HALT;
            endcase
        end
    end

    assign bus.out     = out_q;
    assign bus.tc      = tc_q;
    assign bus.match   = match_q;
    assign bus.running = (state_q == ST_RUN);
endmodule
